mini_cpu_core: RTL
==================

// Module: mini_cpu_core
// PURPOSE
//   Parametrised multi-cycle successor of the 8-bit teaching CPU: same 4-op ISA (ADD/LD/ST/BEQ), generic data width,
//   register count and data-memory depth. Fetches instructions from an external instruction ROM with a req/valid
//   handshake, adds run/single-step control, a halt state and a debug register read port for the 7-seg console.
// PARAMETERS
//   DATA_W      8   register / data-memory word width (bits)
//   REG_AW      2   register index width; NREG = 2**REG_AW registers
//   PC_W        8   program counter / instruction address width
//   DMEM_AW     5   data-memory address width; depth = 2**DMEM_AW words
//   INSTR_W = 2 + 3*REG_AW (localparam, 8 at defaults)
// PORTS
//   clock       in   1         system clock, all state on rising edge
//   reset       in   1         synchronous, active-high; one clock; reset is synchronous and active-high
//   run         in   1         level: free-run while high
//   step        in   1         pulse: execute exactly one instruction when IDLE and run low
//   imem_req    out  1         instruction fetch request
//   imem_addr   out  PC_W      fetch address (= pc)
//   imem_valid  in   1         imem_data valid; accepted when imem_req high
//   imem_data   in   INSTR_W   instruction word
//   dbg_sel     in   REG_AW    debug register select
//   dbg_data    out  DATA_W    registers[dbg_sel], combinational
//   pc          out  PC_W      program counter
//   op          out  2         opcode of latched instruction (ir[INSTR_W-1 -: 2])
//   reg_write   out  1         1-cycle pulse in EXEC for ADD/LD
//   mem_write   out  1         1-cycle pulse in EXEC for ST
//   mem_read    out  1         1-cycle pulse in EXEC for LD
//   last_reg    out  REG_AW    index of last register written
//   busy        out  1         state is FETCH or EXEC
//   halted      out  1         state is HALT
// BEHAVIOUR
//   Fields: op=ir[top 2], rs=next REG_AW, rt=next REG_AW, rd/imm=low REG_AW. imm sign-extended to DATA_W (branch: PC_W).
//   ADD: R[rd] <= R[rs]+R[rt] mod 2**DATA_W; last_reg<=rd.
//   LD : R[rt] <= M[(R[rs]+imm) low DMEM_AW bits]; last_reg<=rt.  ST: M[(R[rs]+imm) low DMEM_AW] <= R[rt].
//   BEQ: if R[rs]==R[rt] pc<=pc+1+imm else pc<=pc+1 (rs==rt encodes unconditional jump). Others: pc<=pc+1, wraps mod 2**PC_W.
//   R0 is an ordinary writable register. Address arithmetic wraps (no fault).
//   FSM: IDLE -> FETCH when run=1 or step=1. FETCH: imem_req=1, imem_addr=pc; stays until imem_valid, then ir<=imem_data,
//     -> EXEC. EXEC (exactly 1 cycle): commit op, update pc, pulse strobes; then HALT if BEQ taken with imm=-1
//     (target==pc, pc unchanged), else FETCH if run=1, else IDLE. HALT: sticky until reset; no req, no strobes.
//   Throughput: min 2 cycles/instr (FETCH with imem_valid same cycle + EXEC). imem_valid outside FETCH ignored.
//   step while busy or run high ignored. run dropping mid-instruction completes that instruction, then IDLE.
//   Reset (priority over everything, incl. mid-FETCH/EXEC): state IDLE, pc=0, ir=0, all R=0, last_reg=0, all strobes 0,
//     imem_req=0, busy=0, halted=0; data memory re-initialised: M[i]=i for i<depth/2, M[i]=-(i-depth/2) otherwise.
//   dbg_data reflects register contents after the EXEC edge (old value during the write cycle).
// TESTING
//   T1 reset, run=1, ROM {0x45,0x16}: LD r1=M[0+1]=1, ADD r2=r1+r1 -> dbg_sel=2 gives 0x02, pc=2, last_reg=2.
//   T2 after T1, {0x9B,0x4C}: ST r2->M[r1-1=0], LD r3=M[0] -> r3=0x02; mem_write then mem_read pulse once each.
//   T3 r1=1,r0=0: 0xD1 (BEQ r1,r0,+1) -> pc+1; 0xC1 (BEQ r0,r0,+1) -> pc+2; 0xC3 -> halted=1, pc unchanged, imem_req stays 0.
//   T4 run=0, single step pulse with 0x45 -> exactly one EXEC, r1=1, pc=1, back to IDLE, busy=0.
//   T5 imem_valid held low 5 cycles in FETCH -> imem_req held, no state change; reset asserted then -> IDLE, pc=0, regs 0.
//   T6 LD with address wrap: r1=0x1F, 0x55 (LD r1=M[r1+1]) -> M[0]=0; r1=0x10, 0x55 -> M[17]=0xFF.

Source files
------------

// File: rtl/mini_cpu_core.sv
// mini_cpu_core: multi-cycle 4-op CPU (ADD/LD/ST/BEQ) with parametrised widths,
// external instruction ROM fetched over a req/valid handshake, run/single-step
// control, a sticky halt state and a combinational debug register read port.
module mini_cpu_core #(
  parameter int DATA_W  = 8,
  parameter int REG_AW  = 2,
  parameter int PC_W    = 8,
  parameter int DMEM_AW = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    step,
  output logic                    imem_req,
  output logic [PC_W-1:0]         imem_addr,
  input  logic                    imem_valid,
  input  logic [2+3*REG_AW-1:0]   imem_data,
  input  logic [REG_AW-1:0]       dbg_sel,
  output logic [DATA_W-1:0]       dbg_data,
  output logic [PC_W-1:0]         pc,
  output logic [1:0]              op,
  output logic                    reg_write,
  output logic                    mem_write,
  output logic                    mem_read,
  output logic [REG_AW-1:0]       last_reg,
  output logic                    busy,
  output logic                    halted
);

  localparam int          INSTR_W = 2 + 3*REG_AW;
  localparam int          NREG    = 2**REG_AW;
  localparam int unsigned DEPTH   = 2**DMEM_AW;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LD  = 2'b01;
  localparam logic [1:0] OP_ST  = 2'b10;
  localparam logic [1:0] OP_BEQ = 2'b11;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [REG_AW-1:0]  last_reg_q, last_reg_d;
  logic [DATA_W-1:0]  regs_q [NREG];
  logic [DATA_W-1:0]  mem_q  [DEPTH];

  // Decoded instruction fields and operands
  logic [1:0]          op_w;
  logic [REG_AW-1:0]   rs, rt, rd;
  logic [DATA_W-1:0]   rs_val, rt_val;
  logic [PC_W-1:0]     imm_pc, pc_inc, pc_br;
  logic [DMEM_AW-1:0]  imm_a, dm_addr;
  logic                eq;

  // Single register-file and data-memory write ports, driven from EXEC
  logic                rf_we;
  logic [REG_AW-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;
  logic                dm_we;

  assign op_w   = ir_q[INSTR_W-1 -: 2];
  assign rs     = ir_q[3*REG_AW-1 -: REG_AW];
  assign rt     = ir_q[2*REG_AW-1 -: REG_AW];
  assign rd     = ir_q[REG_AW-1:0];
  assign rs_val = regs_q[rs];
  assign rt_val = regs_q[rt];
  assign eq     = (rs_val == rt_val);

  // Address arithmetic only needs the low DMEM_AW bits, so the immediate is
  // sign-extended straight to that width; the sum wraps naturally.
  assign imm_a   = {{(DMEM_AW-REG_AW){rd[REG_AW-1]}}, rd};
  assign dm_addr = rs_val[DMEM_AW-1:0] + imm_a;
  assign imm_pc  = {{(PC_W-REG_AW){rd[REG_AW-1]}}, rd};
  assign pc_inc  = pc_q + PC_ONE;
  assign pc_br   = pc_inc + imm_pc;

  // Next-state, PC, IR and write-port decode
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    last_reg_d = last_reg_q;
    rf_we      = 1'b0;
    rf_waddr   = rd;
    rf_wdata   = rs_val + rt_val;
    dm_we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run || step) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        pc_d = pc_inc;
        case (op_w)
          OP_ADD: begin
            rf_we      = 1'b1;
            rf_waddr   = rd;
            rf_wdata   = rs_val + rt_val;
            last_reg_d = rd;
          end
          OP_LD: begin
            rf_we      = 1'b1;
            rf_waddr   = rt;
            rf_wdata   = mem_q[dm_addr];
            last_reg_d = rt;
          end
          OP_ST: begin
            dm_we = 1'b1;
          end
          default: begin
            if (eq) pc_d = pc_br;
          end
        endcase
        // A taken branch to itself (imm = -1) is the halt idiom.
        if (op_w == OP_BEQ && eq && rd == '1) state_d = ST_HALT;
        else if (run)                         state_d = ST_FETCH;
        else                                  state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // Control state, PC, IR and last-written index
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      last_reg_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      last_reg_q <= last_reg_d;
    end
  end

  // Register file: cleared on reset, one write per EXEC
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[REG_AW'(i)] <= '0;
    end else if (rf_we) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

  // Data memory: reset loads i in the lower half and -(i-depth/2) in the upper half
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (i < DEPTH/2) mem_q[DMEM_AW'(i)] <= DATA_W'(i);
        else             mem_q[DMEM_AW'(i)] <= '0 - DATA_W'(i - DEPTH/2);
      end
    end else if (dm_we) begin
      mem_q[dm_addr] <= rt_val;
    end
  end

  assign imem_req  = (state_q == ST_FETCH);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign op        = op_w;
  assign last_reg  = last_reg_q;
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_EXEC);
  assign halted    = (state_q == ST_HALT);
  assign reg_write = (state_q == ST_EXEC) && (op_w == OP_ADD || op_w == OP_LD);
  assign mem_write = (state_q == ST_EXEC) && (op_w == OP_ST);
  assign mem_read  = (state_q == ST_EXEC) && (op_w == OP_LD);
  assign dbg_data  = regs_q[dbg_sel];

endmodule
